// File: rtl/yd_int_ctrl.sv
// yd_int_ctrl: single-source interrupt controller for the Yduck 16-bit core.
// It sits between the core's two register-file write ports and the register file.
// On an accepted interrupt it takes over both write ports for one cycle. Port 0
// writes the vector into the PC register. Port 1 saves the current PC.
// The "in interrupt" state stays set until the ISR jumps back to the saved PC.
//
// Optional build macro YD_INT_PENDING_EN adds a pending flop. A request that
// arrives while the controller is not ready is latched and serviced at the
// first ready cycle. Without the macro, the source must hold int_vld.
//
// Handshake: int_vld/int_rdy complete in the same cycle (acc = req & int_rdy).
// int_rdy never depends on int_vld. The source may drop int_vld only after a
// cycle in which both were high.
module yd_int_ctrl #(
    parameter int              DW        = 16,
    parameter int              AW        = 4,
    parameter logic [AW-1:0]   PC_ADDR   = 4'hF,
    parameter logic [AW-1:0]   SAVE_ADDR = 4'hE,
    parameter logic [DW-1:0]   INT_VEC   = 16'h0010
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          int_vld,
    output logic          int_rdy,
    input  logic [DW-1:0] PC,
    input  logic          jpc,
    output logic          int_jpc,
    output logic          inp,
    input  logic [DW-1:0] din0,
    input  logic [AW-1:0] waddr0,
    input  logic          we0,
    input  logic [DW-1:0] din1,
    input  logic [AW-1:0] waddr1,
    input  logic          we1,
    output logic [DW-1:0] int_din0,
    output logic [AW-1:0] int_waddr0,
    output logic          int_we0,
    output logic [DW-1:0] int_din1,
    output logic [AW-1:0] int_waddr1,
    output logic          int_we1
);

    logic          inp_q, inp_d;
    logic [DW-1:0] epc_q, epc_d;
    logic          req;
    logic          acc;
    logic          ret;

`ifdef YD_INT_PENDING_EN
    logic          pending_q, pending_d;
`endif

    // Handshake decode: ready, effective request, accept and return detection.
    always_comb begin
        int_rdy = ~rst & ~inp_q & ~jpc;
`ifdef YD_INT_PENDING_EN
        req     = int_vld | pending_q;
`else
        req     = int_vld;
`endif
        acc     = req & int_rdy;
        ret     = inp_q & jpc & we0 & (waddr0 == PC_ADDR) & (din0 == epc_q);
    end

    // Write-port mux: pass the core through, or hijack both ports on accept.
    // The squashed core writes re-execute after return, because their PC is
    // the value that gets saved.
    always_comb begin
        int_din0   = din0;
        int_waddr0 = waddr0;
        int_we0    = we0;
        int_din1   = din1;
        int_waddr1 = waddr1;
        int_we1    = we1;
        int_jpc    = jpc;
        if (acc) begin
            int_din0   = INT_VEC;
            int_waddr0 = PC_ADDR;
            int_we0    = 1'b1;
            int_din1   = PC;
            int_waddr1 = SAVE_ADDR;
            int_we1    = 1'b1;
            int_jpc    = 1'b1;
        end
    end

    // Next-state logic. Priority is rst > ret > acc.
    // acc and ret are mutually exclusive, because int_rdy is low while inp is set.
    always_comb begin
        inp_d = inp_q;
        epc_d = epc_q;
        if (rst) begin
            inp_d = 1'b0;
            epc_d = '0;
        end else if (ret) begin
            inp_d = 1'b0;
        end else if (acc) begin
            inp_d = 1'b1;
            epc_d = PC;
        end
    end

`ifdef YD_INT_PENDING_EN
    // Pending latch: remember a request that arrived while not ready.
    always_comb begin
        pending_d = pending_q;
        if (rst) begin
            pending_d = 1'b0;
        end else if (acc) begin
            pending_d = 1'b0;
        end else if (int_vld & ~int_rdy) begin
            pending_d = 1'b1;
        end
    end

    // Pending flop.
    always_ff @(posedge clk) begin
        pending_q <= pending_d;
    end
`endif

    // State registers.
    always_ff @(posedge clk) begin
        inp_q <= inp_d;
        epc_q <= epc_d;
    end

    assign inp = inp_q;

endmodule

// File: tb/tb_yd_int_ctrl.sv
// Directed testbench for yd_int_ctrl. It covers pass-through, entry, ISR jump,
// return, blocked requests, and reset in the middle of an ISR.
module tb_yd_int_ctrl;

  logic        clk;
  logic        rst;
  logic        int_vld;
  logic        int_rdy;
  logic [15:0] pc;
  logic        jpc;
  logic        int_jpc;
  logic        inp;
  logic [15:0] din0, din1;
  logic [3:0]  waddr0, waddr1;
  logic        we0, we1;
  logic [15:0] int_din0, int_din1;
  logic [3:0]  int_waddr0, int_waddr1;
  logic        int_we0, int_we1;

  int total = 0;
  int bad   = 0;

  yd_int_ctrl dut (
    .clk(clk), .rst(rst), .int_vld(int_vld), .int_rdy(int_rdy),
    .PC(pc), .jpc(jpc), .int_jpc(int_jpc), .inp(inp),
    .din0(din0), .waddr0(waddr0), .we0(we0),
    .din1(din1), .waddr1(waddr1), .we1(we1),
    .int_din0(int_din0), .int_waddr0(int_waddr0), .int_we0(int_we0),
    .int_din1(int_din1), .int_waddr1(int_waddr1), .int_we1(int_we1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks. Inputs change 1 ns after the rising edge, and checks run 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic j, input logic [15:0] p,
                       input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                       input logic w1, input logic [3:0] a1, input logic [15:0] d1);
    int_vld = v; jpc = j; pc = p;
    we0 = w0; waddr0 = a0; din0 = d0;
    we1 = w1; waddr1 = a1; din1 = d1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0100, 1'b1, 4'h6, 16'h0066, 1'b0, 4'h7, 16'h0077);
    step();
    #1;
    total++; if (inp !== 1'b0) begin bad++; $display("FAIL reset_inp got=%b exp=0", inp); end
    total++; if (int_rdy !== 1'b0) begin bad++; $display("FAIL reset_rdy got=%b exp=0", int_rdy); end
    total++; if (int_waddr0 !== 4'h6 || int_din0 !== 16'h0066 || int_we0 !== 1'b1)
      begin bad++; $display("FAIL reset_pass0 got=%b/%h/%h exp=1/6/0066", int_we0, int_waddr0, int_din0); end
    total++; if (int_jpc !== 1'b0 || int_we1 !== 1'b0)
      begin bad++; $display("FAIL reset_jpc_we1 got=%b/%b exp=0/0", int_jpc, int_we1); end
    // Release reset with no request. A request seen only during reset must be dropped.
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0100, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (int_jpc !== 1'b0 || int_we0 !== 1'b0)
      begin bad++; $display("FAIL reset_release_noacc got=%b/%b exp=0/0", int_jpc, int_we0); end
    total++; if (int_rdy !== 1'b1) begin bad++; $display("FAIL reset_release_rdy got=%b exp=1", int_rdy); end
  endtask

  task automatic test_pass_through();
    step();
    drive(1'b0, 1'b0, 16'h1234, 1'b1, 4'h1, 16'h0031, 1'b1, 4'h2, 16'h0032);
    total++; if (int_we0 !== 1'b1 || int_waddr0 !== 4'h1 || int_din0 !== 16'h0031)
      begin bad++; $display("FAIL pass_port0 got=%b/%h/%h exp=1/1/0031", int_we0, int_waddr0, int_din0); end
    total++; if (int_we1 !== 1'b1 || int_waddr1 !== 4'h2 || int_din1 !== 16'h0032)
      begin bad++; $display("FAIL pass_port1 got=%b/%h/%h exp=1/2/0032", int_we1, int_waddr1, int_din1); end
    total++; if (int_jpc !== 1'b0 || inp !== 1'b0 || int_rdy !== 1'b1)
      begin bad++; $display("FAIL pass_ctrl got jpc=%b inp=%b rdy=%b exp=0/0/1", int_jpc, inp, int_rdy); end
  endtask

  task automatic test_entry();
    step();
    drive(1'b1, 1'b0, 16'h1234, 1'b1, 4'h3, 16'hAAAA, 1'b1, 4'h4, 16'hBBBB);
    total++; if (int_we0 !== 1'b1 || int_waddr0 !== 4'hF || int_din0 !== 16'h0010)
      begin bad++; $display("FAIL entry_port0 got=%b/%h/%h exp=1/F/0010", int_we0, int_waddr0, int_din0); end
    total++; if (int_we1 !== 1'b1 || int_waddr1 !== 4'hE || int_din1 !== 16'h1234)
      begin bad++; $display("FAIL entry_port1 got=%b/%h/%h exp=1/E/1234", int_we1, int_waddr1, int_din1); end
    total++; if (int_jpc !== 1'b1) begin bad++; $display("FAIL entry_jpc got=%b exp=1", int_jpc); end
    step();
    drive(1'b0, 1'b0, 16'h0010, 1'b1, 4'h3, 16'hAAAA, 1'b1, 4'h4, 16'hBBBB);
    total++; if (inp !== 1'b1 || int_rdy !== 1'b0)
      begin bad++; $display("FAIL entry_state got inp=%b rdy=%b exp=1/0", inp, int_rdy); end
    total++; if (int_waddr0 !== 4'h3 || int_din0 !== 16'hAAAA || int_waddr1 !== 4'h4 || int_din1 !== 16'hBBBB || int_jpc !== 1'b0)
      begin bad++; $display("FAIL entry_after_pass got=%h/%h/%h/%h/%b exp=3/AAAA/4/BBBB/0", int_waddr0, int_din0, int_waddr1, int_din1, int_jpc); end
`ifndef YD_INT_PENDING_EN
    // No nesting: a request during the ISR does not override the ports.
    step();
    drive(1'b1, 1'b0, 16'h0011, 1'b1, 4'h5, 16'h0505, 1'b0, 4'h0, 16'h0000);
    total++; if (int_waddr0 !== 4'h5 || int_din0 !== 16'h0505 || int_jpc !== 1'b0 || int_rdy !== 1'b0)
      begin bad++; $display("FAIL nest_ignored got=%h/%h/%b/%b exp=5/0505/0/0", int_waddr0, int_din0, int_jpc, int_rdy); end
`endif
  endtask

  task automatic test_isr_jump();
    step();
    drive(1'b0, 1'b1, 16'h0012, 1'b1, 4'hF, 16'h1FFF, 1'b0, 4'h0, 16'h0000);
    total++; if (int_jpc !== 1'b1 || int_we0 !== 1'b1 || int_waddr0 !== 4'hF || int_din0 !== 16'h1FFF)
      begin bad++; $display("FAIL isr_jump_pass got=%b/%b/%h/%h exp=1/1/F/1FFF", int_jpc, int_we0, int_waddr0, int_din0); end
    step();
    drive(1'b0, 1'b0, 16'h1FFF, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (inp !== 1'b1) begin bad++; $display("FAIL isr_jump_inp got=%b exp=1", inp); end
  endtask

  task automatic test_return();
    step();
    drive(1'b0, 1'b1, 16'h2000, 1'b1, 4'hF, 16'h1234, 1'b0, 4'h0, 16'h0000);
    total++; if (int_jpc !== 1'b1 || int_waddr0 !== 4'hF || int_din0 !== 16'h1234 || int_we1 !== 1'b0)
      begin bad++; $display("FAIL return_pass got=%b/%h/%h/%b exp=1/F/1234/0", int_jpc, int_waddr0, int_din0, int_we1); end
    step();
    drive(1'b0, 1'b0, 16'h1234, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (inp !== 1'b0 || int_rdy !== 1'b1)
      begin bad++; $display("FAIL return_state got inp=%b rdy=%b exp=0/1", inp, int_rdy); end
  endtask

  task automatic test_blocked_jump();
    step();
    drive(1'b1, 1'b1, 16'h2222, 1'b1, 4'h5, 16'h0055, 1'b0, 4'h0, 16'h0000);
    total++; if (int_rdy !== 1'b0 || int_waddr0 !== 4'h5 || int_din0 !== 16'h0055 || int_we1 !== 1'b0)
      begin bad++; $display("FAIL blocked_pass got=%b/%h/%h/%b exp=0/5/0055/0", int_rdy, int_waddr0, int_din0, int_we1); end
    step();
    drive(1'b0, 1'b0, 16'h2222, 1'b1, 4'h6, 16'h0066, 1'b0, 4'h0, 16'h0000);
    total++; if (inp !== 1'b0) begin bad++; $display("FAIL blocked_inp got=%b exp=0", inp); end
`ifdef YD_INT_PENDING_EN
    total++; if (int_jpc !== 1'b1 || int_waddr0 !== 4'hF || int_din0 !== 16'h0010 || int_waddr1 !== 4'hE || int_din1 !== 16'h2222)
      begin bad++; $display("FAIL pending_acc got=%b/%h/%h/%h/%h exp=1/F/0010/E/2222", int_jpc, int_waddr0, int_din0, int_waddr1, int_din1); end
    step();
    drive(1'b0, 1'b0, 16'h0010, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (inp !== 1'b1) begin bad++; $display("FAIL pending_inp got=%b exp=1", inp); end
`else
    total++; if (int_jpc !== 1'b0 || int_waddr0 !== 4'h6 || int_din0 !== 16'h0066)
      begin bad++; $display("FAIL blocked_dropped got=%b/%h/%h exp=0/6/0066", int_jpc, int_waddr0, int_din0); end
    step();
    drive(1'b0, 1'b0, 16'h2223, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (inp !== 1'b0) begin bad++; $display("FAIL blocked_inp2 got=%b exp=0", inp); end
`endif
  endtask

  task automatic test_reset_mid_isr();
    // Start from a clean state. The previous test may have left an ISR running.
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    step();
    rst = 1'b0;
    drive(1'b1, 1'b0, 16'h4321, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (int_din1 !== 16'h4321 || int_jpc !== 1'b1)
      begin bad++; $display("FAIL entry2 got=%h/%b exp=4321/1", int_din1, int_jpc); end
    step();
    // A jump to the old return address 1234 must not end this ISR. epc is now 4321.
    drive(1'b0, 1'b1, 16'h0010, 1'b1, 4'hF, 16'h1234, 1'b0, 4'h0, 16'h0000);
    step();
    drive(1'b0, 1'b0, 16'h1234, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (inp !== 1'b1) begin bad++; $display("FAIL stale_ret_inp got=%b exp=1", inp); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h1234, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (int_rdy !== 1'b0 || int_jpc !== 1'b0)
      begin bad++; $display("FAIL rst_mid_comb got rdy=%b jpc=%b exp=0/0", int_rdy, int_jpc); end
    step();
    total++; if (inp !== 1'b0 || int_rdy !== 1'b0)
      begin bad++; $display("FAIL rst_mid_state got inp=%b rdy=%b exp=0/0", inp, int_rdy); end
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    total++; if (int_rdy !== 1'b1) begin bad++; $display("FAIL rst_mid_release got=%b exp=1", int_rdy); end
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 4'h0, 16'h0000, 1'b0, 4'h0, 16'h0000);
    test_reset();
    test_pass_through();
    test_entry();
    test_isr_jump();
    test_return();
    test_blocked_jump();
    test_reset_mid_isr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yd_int_ctrl.md
Name: yd_int_ctrl

Overview:
- Single-source interrupt controller for the Yduck 16-bit core.
- Sits between the core's two register-file write ports and the register file.
- Normally passes core writes and the jump strobe straight through.
- On an accepted interrupt, it takes over both write ports for one cycle to save the PC and redirect execution to a fixed vector.
- It tracks "in interrupt" state until the ISR returns to the saved PC.

Parameters:
- DW, 16, data/PC width
- AW, 4, register address width
- PC_ADDR, 4'hF, register-file address of the PC register
- SAVE_ADDR, 4'hE, register that receives the saved PC on interrupt entry
- INT_VEC, 16'h0010, interrupt vector written to PC_ADDR

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- int_vld  in  1  interrupt request (valid side of handshake)
- int_rdy  out  1  controller can accept an interrupt this cycle
- PC  in  DW  address of the instruction whose writes occur this cycle
- jpc  in  1  core jump strobe (core writes PC this cycle)
- int_jpc  out  1  jump strobe to core/fetch
- inp  out  1  interrupt in progress (ISR executing)
- din0, waddr0, we0  in  DW/AW/1  core write port 0
- din1, waddr1, we1  in  DW/AW/1  core write port 1
- int_din0, int_waddr0, int_we0  out  DW/AW/1  write port 0 to register file
- int_din1, int_waddr1, int_we1  out  DW/AW/1  write port 1 to register file

Behaviour:
- State registers: inp (1 bit), epc (DW bits).
- Reset values: inp=0, epc=0.
- While rst=1: int_rdy=0, and all data outputs pass through.
- int_rdy = ~rst & ~inp & ~jpc (combinational).
- Accept condition: acc = int_vld & int_rdy. Handshake completes in the same cycle; zero latency.
- Pass-through when acc=0: int_din/waddr/we{0,1} = din/waddr/we{0,1}, and int_jpc = jpc.
- When acc=1, outputs are overridden combinationally in that same cycle:
  - port0: int_we0=1, int_waddr0=PC_ADDR, int_din0=INT_VEC
  - port1: int_we1=1, int_waddr1=SAVE_ADDR, int_din1=PC
  - int_jpc=1
  - Core we0/we1 are squashed; that instruction re-executes after return because its own PC is the value saved.
- On the edge after acc: inp<=1, epc<=PC.
- Return detection (ret) requires all of: inp=1, jpc=1, we0=1, waddr0==PC_ADDR, din0==epc.
  - ret passes through unmodified.
  - inp<=0 on that edge.
- Jumps inside the ISR to any other target do not clear inp.
- Priority: rst > ret > acc. acc cannot coincide with ret because int_rdy=0 while inp=1.
- int_vld while not ready is ignored; the source must hold it. With the optional feature enabled, it is latched instead.
- No nesting: int_vld during the ISR has no effect until inp falls.
- inp is registered. All other outputs are combinational from the inputs and state.

Optional Feature:
- Macro: YD_INT_PENDING_EN.
- Enabled:
  - A pending flop (reset 0) is set by int_vld whenever int_rdy=0, and cleared on acceptance.
  - Effective request = int_vld | pending, so a one-cycle pulse arriving during the ISR or a jump is serviced at the first ready cycle.
- Disabled:
  - No pending flop; only int_vld in a ready cycle is accepted.

Test Plan:
- Pass-through: rst released, PC=16'h1234; we0=1/waddr0=1/din0=16'h0031 and we1=1/waddr1=2/din1=16'h0032 -> int ports mirror these exactly, int_jpc=0, inp=0, int_rdy=1.
- Entry: int_vld=1 for 1 cycle, PC=16'h1234, core writes to regs 3 and 4 -> same cycle int_we0=1/addr F/data 16'h0010 and int_we1=1/addr E/data 16'h1234, int_jpc=1; next cycle inp=1, int_rdy=0, writes pass through again.
- ISR jump: inp=1, jpc=1, we0=1, waddr0=F, din0=16'h1FFF -> pass-through, int_jpc=1, inp stays 1.
- Return: jpc=1, we0=1, waddr0=F, din0=16'h1234 -> pass-through; inp=0 and int_rdy=1 next cycle.
- Blocked: int_vld=1 with jpc=1, or during rst -> no override, inp stays 0. With YD_INT_PENDING_EN, acceptance occurs on the first cycle jpc=0.
- Reset mid-ISR: rst=1 while inp=1 -> inp=0 next edge, int_rdy=0 while rst is high.
